// File: rtl/fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_rptr_empty
//  Description : Read-side pointer and flag logic for an asynchronous FIFO.
//                Keeps the binary read pointer and the Gray read pointer that
//                goes to the write-domain synchronizer. Also produces the
//                empty, almost-empty, occupancy and sticky underflow flags,
//                all registered in the read clock domain.
//
//  Parameters  : WIDTH          address bits; depth is 2**WIDTH and
//                               pointers are WIDTH+1 bits wide
//                AEMPTY_THRESH  almost-empty occupancy threshold
//                               (0 .. 2**WIDTH-1)
//
//  Ports       : rclk        in   read-domain clock (rising edge)
//                rrst        in   synchronous active-high reset
//                rinc        in   read request from the consumer
//                rq2_wptr    in   Gray write pointer, already synchronized
//                                 into rclk
//                raddr       out  binary read address to the FIFO memory
//                rptr        out  registered Gray read pointer
//                rempty      out  registered empty flag
//                raempty     out  registered almost-empty flag
//                rcount      out  registered occupancy seen from read side
//                runderflow  out  sticky flag: read requested while empty
//
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_rptr_empty #(
    parameter int WIDTH         = 8,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [WIDTH:0]   rq2_wptr,
    output logic [WIDTH-1:0] raddr,
    output logic [WIDTH:0]   rptr,
    output logic             rempty,
    output logic             raempty,
    output logic [WIDTH:0]   rcount,
    output logic             runderflow
);

    localparam logic [WIDTH:0] c_aempty_thresh = AEMPTY_THRESH[WIDTH:0];
    localparam logic [WIDTH:0] c_one           = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0] r_rbin;
    logic           w_rd_accept;
    logic [WIDTH:0] w_rbin_next;
    logic [WIDTH:0] w_rgray_next;
    logic [WIDTH:0] w_wbin;
    logic [WIDTH:0] w_count_next;

    // A read is taken only when the FIFO is not already flagged empty; a
    // request while empty leaves the pointer alone and raises underflow.
    assign w_rd_accept  = rinc & ~rempty;
    // Addition wraps naturally at 2**(WIDTH+1), so the pointer rolls over
    // without any special case.
    assign w_rbin_next  = w_rd_accept ? (r_rbin + c_one) : r_rbin;
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above its position. Written as a reduction per bit so there is no
    // ripple through the vector itself.
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_wgray2bin
        assign w_wbin[gi] = ^(rq2_wptr >> gi);
    end

    // Uses the freshly synchronized write pointer and the post-read pointer
    // together, so a read and a write in the same cycle cancel out.
    assign w_count_next = w_wbin - w_rbin_next;

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_rbin     <= '0;
            rptr       <= '0;
            rempty     <= 1'b1;
            raempty    <= 1'b1;
            rcount     <= '0;
            runderflow <= 1'b0;
        end else begin
            r_rbin     <= w_rbin_next;
            rptr       <= w_rgray_next;
            // Gray codes are equal exactly when the binary values are, so
            // this agrees with rcount reaching zero.
            rempty     <= (w_rgray_next == rq2_wptr);
            raempty    <= (w_count_next <= c_aempty_thresh);
            rcount     <= w_count_next;
            runderflow <= runderflow | (rinc & rempty);
        end
    end

    assign raddr = r_rbin[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fifo_rptr_empty.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_rptr_empty
//  Description : Self-checking bench for fifo_rptr_empty (WIDTH=4,
//                AEMPTY_THRESH=4). Each directed step pushes its expected
//                outputs to a scoreboard queue. The entry is popped and
//                compared one time unit after the clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_rptr_empty;

    localparam int WIDTH         = 4;
    localparam int AEMPTY_THRESH = 4;

    typedef struct packed {
        logic [WIDTH:0] rbin;
        logic           e;
        logic           ae;
        logic [WIDTH:0] c;
        logic           u;
    } exp_t;

    logic             rclk;
    logic             rrst;
    logic             rinc;
    logic [WIDTH:0]   rq2_wptr;
    logic [WIDTH-1:0] raddr;
    logic [WIDTH:0]   rptr;
    logic             rempty;
    logic             raempty;
    logic [WIDTH:0]   rcount;
    logic             runderflow;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [WIDTH:0] prev_rptr;

    fifo_rptr_empty #(
        .WIDTH         (WIDTH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
        .rinc       (rinc),
        .rq2_wptr   (rq2_wptr),
        .raddr      (raddr),
        .rptr       (rptr),
        .rempty     (rempty),
        .raempty    (raempty),
        .rcount     (rcount),
        .runderflow (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [WIDTH:0] gray(input logic [WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of stimulus, record what the DUT must show after the
    // edge, then pop and compare that record once the edge has passed.
    task automatic step(input string tag, input logic rst, input logic inc,
                        input logic [WIDTH:0] wq, input exp_t e);
        exp_t got;
        rrst     = rst;
        rinc     = inc;
        rq2_wptr = wq;
        sb_q.push_back(e);
        @(posedge rclk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_raddr"},      32'(raddr),      32'(got.rbin[WIDTH-1:0]));
            chk({tag, "_rptr"},       32'(rptr),       32'(gray(got.rbin)));
            chk({tag, "_rempty"},     32'(rempty),     32'(got.e));
            chk({tag, "_raempty"},    32'(raempty),    32'(got.ae));
            chk({tag, "_rcount"},     32'(rcount),     32'(got.c));
            chk({tag, "_runderflow"}, 32'(runderflow), 32'(got.u));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rrst = 1'b1; rinc = 1'b1; rq2_wptr = 5'b00110;

        // Reset held for two edges with active-looking inputs.
        step("rst0", 1'b1, 1'b1, 5'b00110, '{5'd0, 1'b1, 1'b1, 5'd0, 1'b0});
        step("rst1", 1'b1, 1'b1, 5'b00110, '{5'd0, 1'b1, 1'b1, 5'd0, 1'b0});

        // Fill to 3 entries, then drain them.
        step("fill",   1'b0, 1'b0, 5'b00010, '{5'd0, 1'b0, 1'b1, 5'd3, 1'b0});
        step("drain1", 1'b0, 1'b1, 5'b00010, '{5'd1, 1'b0, 1'b1, 5'd2, 1'b0});
        step("drain2", 1'b0, 1'b1, 5'b00010, '{5'd2, 1'b0, 1'b1, 5'd1, 1'b0});
        step("drain3", 1'b0, 1'b1, 5'b00010, '{5'd3, 1'b1, 1'b1, 5'd0, 1'b0});

        // Read while empty: pointer holds, underflow sticks.
        step("undf", 1'b0, 1'b1, 5'b00010, '{5'd3, 1'b1, 1'b1, 5'd0, 1'b1});
        for (int i = 0; i < 10; i++)
            step("undf_idle", 1'b0, 1'b0, 5'b00010, '{5'd3, 1'b1, 1'b1, 5'd0, 1'b1});

        // Almost-empty boundary: occupancy 4 (at threshold), then 5.
        step("ae_at",   1'b0, 1'b0, gray(5'd7), '{5'd3, 1'b0, 1'b1, 5'd4, 1'b1});
        step("ae_over", 1'b0, 1'b0, gray(5'd8), '{5'd3, 1'b0, 1'b0, 5'd5, 1'b1});

        // Reset in the middle of operation, then restart from rbin=0.
        step("mid_rst",  1'b1, 1'b0, gray(5'd8), '{5'd0, 1'b1, 1'b1, 5'd0, 1'b0});
        step("post_rst", 1'b0, 1'b0, 5'b00011,   '{5'd0, 1'b0, 1'b1, 5'd2, 1'b0});

        // Read every cycle while the write pointer also advances by one:
        // occupancy stays at 2 and rbin walks up to 31.
        prev_rptr = rptr;
        for (int j = 0; j < 31; j++) begin
            step("walk", 1'b0, 1'b1, gray(5'((j + 3) % 32)),
                 '{5'(j + 1), 1'b0, 1'b1, 5'd2, 1'b0});
            chk("rptr_1bit", 32'($countones(rptr ^ prev_rptr) <= 1), 32'd1);
            prev_rptr = rptr;
        end

        // Wrap: rbin=31 (rptr 10000), write pointer bin 1.
        step("wrap_hold", 1'b0, 1'b0, 5'b00001, '{5'd31, 1'b0, 1'b1, 5'd2, 1'b0});
        chk("wrap_rptr_const", 32'(rptr), 32'h10);
        step("wrap_rd1",  1'b0, 1'b1, 5'b00001, '{5'd0,  1'b0, 1'b1, 5'd1, 1'b0});
        chk("wrap_rptr0", 32'(rptr), 32'h00);
        step("wrap_rd2",  1'b0, 1'b1, 5'b00001, '{5'd1,  1'b1, 1'b1, 5'd0, 1'b0});
        chk("wrap_rptr1", 32'(rptr), 32'h01);

        // Read and write in the same cycle with one entry present.
        step("sim_fill", 1'b0, 1'b0, gray(5'd2), '{5'd1, 1'b0, 1'b1, 5'd1, 1'b0});
        step("sim_rw",   1'b0, 1'b1, gray(5'd3), '{5'd2, 1'b0, 1'b1, 5'd1, 1'b0});

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
